// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared op codes, state type and helpers for the memory-access stage
package mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0, LB, LBU, LH, LHU, LW, SB, SH, SW, LD, SD
  } mem_op_e;

  typedef enum logic {LSU_IDLE, LSU_ACCESS} lsu_state_e;

  localparam logic [7:0] BE_NONE = 8'hFF;

  function automatic logic is_load(mem_op_e op);
    return op inside {LB, LBU, LH, LHU, LW, LD};
  endfunction

  function automatic logic is_store(mem_op_e op);
    return op inside {SB, SH, SW, SD};
  endfunction

  // log2 of the access size in bytes
  function automatic logic [1:0] op_size(mem_op_e op);
    case (op)
      LH, LHU, SH: return 2'd1;
      LW, SW:      return 2'd2;
      LD, SD:      return 2'd3;
      default:     return 2'd0;
    endcase
  endfunction

  function automatic logic is_misaligned(mem_op_e op, logic [2:0] off);
    case (op_size(op))
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - SRAM request/response bus between the LSU and the memory
interface mem_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  localparam int BE_W = DATA_W / 8;

  logic              SRAM_CE;
  logic              SRAM_WE;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [BE_W-1:0]   SRAM_BE;
  logic [DATA_W-1:0] SRAM_WDATA;
  logic [DATA_W-1:0] SRAM_RDATA;
  logic              SRAM_READY;

  modport master (
    output SRAM_CE, SRAM_WE, SRAM_ADDR, SRAM_BE, SRAM_WDATA,
    input  SRAM_RDATA, SRAM_READY
  );

  modport slave (
    input  SRAM_CE, SRAM_WE, SRAM_ADDR, SRAM_BE, SRAM_WDATA,
    output SRAM_RDATA, SRAM_READY
  );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane enables, store replication and load extension
module mem_lane_align
  import mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8,
  localparam int OFF_W  = $clog2(BE_W)
) (
  input  mem_op_e           req_op_i,
  input  logic [OFF_W-1:0]  req_off_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic [BE_W-1:0]   be_n_o,
  output logic [DATA_W-1:0] wdata_o,
  input  mem_op_e           rsp_op_i,
  input  logic [OFF_W-1:0]  rsp_off_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] load_data_o
);

  // Misaligned offsets are rounded down to the natural boundary of the access size
  function automatic logic [OFF_W-1:0] align_off(mem_op_e op, logic [OFF_W-1:0] off);
    return off & ~OFF_W'((32'd1 << op_size(op)) - 32'd1);
  endfunction

  logic [OFF_W-1:0]  req_aoff;
  logic [OFF_W-1:0]  rsp_aoff;
  logic [DATA_W-1:0] shifted;

  assign req_aoff = align_off(req_op_i, req_off_i);
  assign rsp_aoff = align_off(rsp_op_i, rsp_off_i);
  assign be_n_o   = ~BE_W'(((32'd1 << (32'd1 << op_size(req_op_i))) - 32'd1) << req_aoff);
  assign shifted  = rdata_i >> {rsp_aoff, 3'b000};

  always_comb begin
    case (op_size(req_op_i))
      2'd0:    wdata_o = {BE_W{store_data_i[7:0]}};
      2'd1:    wdata_o = {(BE_W/2){store_data_i[15:0]}};
      2'd2:    wdata_o = {(BE_W/4){store_data_i[31:0]}};
      default: wdata_o = store_data_i;
    endcase
  end

  always_comb begin
    case (rsp_op_i)
      LB:      load_data_o = DATA_W'($signed(shifted[7:0]));
      LBU:     load_data_o = DATA_W'(shifted[7:0]);
      LH:      load_data_o = DATA_W'($signed(shifted[15:0]));
      LHU:     load_data_o = DATA_W'(shifted[15:0]);
      LW:      load_data_o = DATA_W'($signed(shifted[31:0]));
      default: load_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM stage: SRAM access with timeout, stall and writeback register
// Optional alignment trap (ADDR_ERR_O) enabled by MEM_ALIGN_CHK_EN.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              VALID_I,
  input  logic [3:0]        MEM_OP,
  input  logic [ADDR_W-1:0] MEM_ADDR_I,
  input  logic [DATA_W-1:0] STORE_DATA_I,
  input  logic              GPR_WE_I,
  input  logic [4:0]        GPR_WADDR_I,
  input  logic [DATA_W-1:0] GPR_WDATA_I,
  mem_lsu_if.master         sram,
  output logic              STALL_REQ,
  output logic              GPR_WE_O,
  output logic [4:0]        GPR_WADDR_O,
  output logic [DATA_W-1:0] GPR_WDATA_O,
  output logic              BUS_ERR_O
`ifdef MEM_ALIGN_CHK_EN
  ,
  output logic              ADDR_ERR_O
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = $clog2(TIMEOUT);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sram_ce_q, sram_ce_d, sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [BE_W-1:0]   sram_be_q, sram_be_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  mem_op_e           op_q, op_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [4:0]        dst_q, dst_d;
  logic              gpr_we_q, gpr_we_d, bus_err_q, bus_err_d;
  logic [4:0]        gpr_waddr_q, gpr_waddr_d;
  logic [DATA_W-1:0] gpr_wdata_q, gpr_wdata_d;
`ifdef MEM_ALIGN_CHK_EN
  logic              addr_err_q, addr_err_d;
`endif

  mem_op_e           op_in;
  logic              mem_req, misalign, timeout_hit;
  logic [BE_W-1:0]   issue_be_n;
  logic [DATA_W-1:0] issue_wdata, load_data;

  assign op_in = mem_op_e'(MEM_OP);
  // LD/SD only exist on a 64-bit bus; elsewhere they fall through as non-memory ops
  assign mem_req = VALID_I && (is_load(op_in) || is_store(op_in))
                   && (DATA_W == 64 || op_size(op_in) != 2'd3);
`ifdef MEM_ALIGN_CHK_EN
  assign misalign = is_misaligned(op_in, 3'(MEM_ADDR_I[OFF_W-1:0]));
`else
  assign misalign = 1'b0;
`endif
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .req_op_i     (op_in),
    .req_off_i    (MEM_ADDR_I[OFF_W-1:0]),
    .store_data_i (STORE_DATA_I),
    .be_n_o       (issue_be_n),
    .wdata_o      (issue_wdata),
    .rsp_op_i     (op_q),
    .rsp_off_i    (off_q),
    .rdata_i      (sram.SRAM_RDATA),
    .load_data_o  (load_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= LSU_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE:   if (mem_req && !misalign) state_d = LSU_ACCESS;
      LSU_ACCESS: if (sram.SRAM_READY || timeout_hit) state_d = LSU_IDLE;
      default:    state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    STALL_REQ    = 1'b0;
    cnt_d        = cnt_q;
    sram_ce_d    = sram_ce_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_be_d    = sram_be_q;
    sram_wdata_d = sram_wdata_q;
    op_d         = op_q;
    off_d        = off_q;
    dst_d        = dst_q;
    gpr_we_d     = 1'b0;
    gpr_waddr_d  = gpr_waddr_q;
    gpr_wdata_d  = gpr_wdata_q;
    bus_err_d    = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
    addr_err_d   = 1'b0;
`endif
    case (state_q)
      LSU_IDLE: begin
        if (mem_req && !misalign) begin
          STALL_REQ    = 1'b1;
          sram_ce_d    = 1'b1;
          sram_we_d    = is_store(op_in);
          sram_addr_d  = {MEM_ADDR_I[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          sram_be_d    = issue_be_n;
          sram_wdata_d = issue_wdata;
          op_d         = op_in;
          off_d        = MEM_ADDR_I[OFF_W-1:0];
          dst_d        = GPR_WADDR_I;
          cnt_d        = '0;
        end else if (mem_req) begin
`ifdef MEM_ALIGN_CHK_EN
          addr_err_d = 1'b1;
`endif
        end else begin
          gpr_we_d    = VALID_I && GPR_WE_I;
          gpr_waddr_d = GPR_WADDR_I;
          gpr_wdata_d = GPR_WDATA_I;
        end
      end
      LSU_ACCESS: begin
        if (sram.SRAM_READY || timeout_hit) begin
          sram_ce_d = 1'b0;
          sram_we_d = 1'b0;
          sram_be_d = BE_NONE[BE_W-1:0];
          cnt_d     = '0;
          if (!sram.SRAM_READY) begin
            bus_err_d = 1'b1;
          end else if (is_load(op_q)) begin
            gpr_we_d    = 1'b1;
            gpr_waddr_d = dst_q;
            gpr_wdata_d = load_data;
          end
        end else begin
          STALL_REQ = 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q        <= '0;
      sram_ce_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_be_q    <= BE_NONE[BE_W-1:0];
      sram_wdata_q <= '0;
      op_q         <= MEM_NONE;
      off_q        <= '0;
      dst_q        <= '0;
      gpr_we_q     <= 1'b0;
      gpr_waddr_q  <= '0;
      gpr_wdata_q  <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sram_ce_q    <= sram_ce_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_be_q    <= sram_be_d;
      sram_wdata_q <= sram_wdata_d;
      op_q         <= op_d;
      off_q        <= off_d;
      dst_q        <= dst_d;
      gpr_we_q     <= gpr_we_d;
      gpr_waddr_q  <= gpr_waddr_d;
      gpr_wdata_q  <= gpr_wdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

`ifdef MEM_ALIGN_CHK_EN
  always_ff @(posedge CLK) begin
    if (RST) addr_err_q <= 1'b0;
    else     addr_err_q <= addr_err_d;
  end
  assign ADDR_ERR_O = addr_err_q;
`endif

  assign sram.SRAM_CE    = sram_ce_q;
  assign sram.SRAM_WE    = sram_we_q;
  assign sram.SRAM_ADDR  = sram_addr_q;
  assign sram.SRAM_BE    = sram_be_q;
  assign sram.SRAM_WDATA = sram_wdata_q;
  assign GPR_WE_O        = gpr_we_q;
  assign GPR_WADDR_O     = gpr_waddr_q;
  assign GPR_WDATA_O     = gpr_wdata_q;
  assign BUS_ERR_O       = bus_err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - table-driven bench with writeback scoreboard for mem_lsu
module tb_mem_lsu;
  import mem_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        VALID_I;
  logic [3:0]  MEM_OP;
  logic [31:0] MEM_ADDR_I, STORE_DATA_I, GPR_WDATA_I, GPR_WDATA_O;
  logic        GPR_WE_I, GPR_WE_O, STALL_REQ, BUS_ERR_O;
  logic [4:0]  GPR_WADDR_I, GPR_WADDR_O;
`ifdef MEM_ALIGN_CHK_EN
  logic        ADDR_ERR_O;
`endif

  mem_lsu_if #(.DATA_W(32), .ADDR_W(32)) sram_if ();

  mem_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .VALID_I(VALID_I), .MEM_OP(MEM_OP), .MEM_ADDR_I(MEM_ADDR_I),
    .STORE_DATA_I(STORE_DATA_I), .GPR_WE_I(GPR_WE_I), .GPR_WADDR_I(GPR_WADDR_I),
    .GPR_WDATA_I(GPR_WDATA_I), .sram(sram_if), .STALL_REQ(STALL_REQ), .GPR_WE_O(GPR_WE_O),
    .GPR_WADDR_O(GPR_WADDR_O), .GPR_WDATA_O(GPR_WDATA_O), .BUS_ERR_O(BUS_ERR_O)
`ifdef MEM_ALIGN_CHK_EN
    , .ADDR_ERR_O(ADDR_ERR_O)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic valid; mem_op_e op; logic [31:0] addr, sdata, rdata; int waits;
    logic gwe; logic [4:0] gwaddr; logic [31:0] gwdata;
    logic exp_we; logic [3:0] exp_be; logic [31:0] exp_addr, exp_wdata;
    int exp_stall; logic exp_gpr_we; logic [31:0] exp_gpr_wdata; logic exp_bus_err;
  } vec_t;

  typedef struct {
    logic we; logic [4:0] waddr; logic [31:0] wdata; logic bus_err;
  } res_t;

  vec_t vecs[$];
  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic valid, input mem_op_e op, input logic [31:0] addr,
      input logic [31:0] sdata, input logic [31:0] rdata, input int waits, input logic gwe,
      input logic [4:0] gwaddr, input logic [31:0] gwdata, input logic exp_we,
      input logic [3:0] exp_be, input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
      input int exp_stall, input logic exp_gpr_we, input logic [31:0] exp_gpr_wdata,
      input logic exp_bus_err);
    vec_t v;
    v.valid = valid; v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.waits = waits;
    v.gwe = gwe; v.gwaddr = gwaddr; v.gwdata = gwdata; v.exp_we = exp_we; v.exp_be = exp_be;
    v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_stall = exp_stall;
    v.exp_gpr_we = exp_gpr_we; v.exp_gpr_wdata = exp_gpr_wdata; v.exp_bus_err = exp_bus_err;
    vecs.push_back(v);
  endfunction

  // Entered and left at posedge+1; consecutive calls issue back-to-back instructions.
  task automatic run_vec(input int k, input vec_t v);
    res_t e;
    int   stalls = 0;
    bit   done = 0;
    VALID_I = v.valid; MEM_OP = v.op; MEM_ADDR_I = v.addr; STORE_DATA_I = v.sdata;
    GPR_WE_I = v.gwe; GPR_WADDR_I = v.gwaddr; GPR_WDATA_I = v.gwdata;
    e.we = v.exp_gpr_we; e.waddr = v.gwaddr; e.wdata = v.exp_gpr_wdata; e.bus_err = v.exp_bus_err;
    sb.push_back(e);
    for (int i = 0; i < 64 && !done; i++) begin
      sram_if.SRAM_READY = (v.waits >= 0) && (i == v.waits + 1);
      sram_if.SRAM_RDATA = sram_if.SRAM_READY ? v.rdata : $urandom;
      @(negedge CLK);
      if (i == 1) begin
        chk($sformatf("v%0d.ce", k), sram_if.SRAM_CE, 1'b1);
        chk($sformatf("v%0d.we", k), sram_if.SRAM_WE, v.exp_we);
        chk($sformatf("v%0d.addr", k), sram_if.SRAM_ADDR, v.exp_addr);
        chk($sformatf("v%0d.be", k), sram_if.SRAM_BE, v.exp_be);
        chk($sformatf("v%0d.wdata", k), sram_if.SRAM_WDATA, v.exp_wdata);
        chk($sformatf("v%0d.bus_err_low", k), BUS_ERR_O, 1'b0);
      end
      if (STALL_REQ) stalls++;
      else done = 1;
      @(posedge CLK); #1;
    end
    sram_if.SRAM_READY = 1'b0;
    VALID_I = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL v%0d.complete: got no completion expected completion within 64 cycles", k);
    end
    chk($sformatf("v%0d.stall_cycles", k), stalls, v.exp_stall);
    e = sb.pop_front();
    chk($sformatf("v%0d.gpr_we", k), GPR_WE_O, e.we);
    if (e.we) begin
      chk($sformatf("v%0d.gpr_waddr", k), GPR_WADDR_O, e.waddr);
      chk($sformatf("v%0d.gpr_wdata", k), GPR_WDATA_O, e.wdata);
    end
    chk($sformatf("v%0d.bus_err", k), BUS_ERR_O, e.bus_err);
    chk($sformatf("v%0d.ce_idle", k), sram_if.SRAM_CE, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test expected end before 400us");
    $fatal(1);
  end

  initial begin
    bit seen;
    RST = 1'b1; VALID_I = 1'b0; MEM_OP = 4'd0; MEM_ADDR_I = '0; STORE_DATA_I = '0;
    GPR_WE_I = 1'b0; GPR_WADDR_I = '0; GPR_WDATA_I = '0;
    sram_if.SRAM_READY = 1'b0; sram_if.SRAM_RDATA = '0;

    //   valid op        addr          sdata         rdata         waits gwe waddr gwdata
    //   | exp_we be   exp_addr      exp_wdata     stall gpr_we gpr_wdata  bus_err
    add(1, MEM_NONE, 32'h0,      32'h0,        32'h0,        0,  1, 5'd5,  32'hDEAD_BEEF, 0, 4'hF, 32'h0,      32'h0,        0,  1, 32'hDEAD_BEEF, 0);
    add(1, LW,       32'h5000,   32'h0,        32'hCAFE_0001, 1, 1, 5'd9,  32'h1111,      0, 4'h0, 32'h5000,   32'h0,        2,  1, 32'hCAFE_0001, 0);
    add(1, LB,       32'h1003,   32'h0,        32'h80FF_0000, 3, 1, 5'd7,  32'h0,         0, 4'h7, 32'h1000,   32'h0,        4,  1, 32'hFFFF_FF80, 0);
    add(1, LHU,      32'h2002,   32'h0,        32'h9ABC_1234, 0, 1, 5'd3,  32'h0,         0, 4'h3, 32'h2000,   32'h0,        1,  1, 32'h0000_9ABC, 0);
    add(1, SB,       32'h3001,   32'h1122_33A5, 32'h0,       1, 0, 5'd4,  32'h0,         1, 4'hD, 32'h3000,   32'hA5A5_A5A5, 2, 0, 32'h0,         0);
    add(1, LH,       32'h4002,   32'h0,        32'h8001_0000, 2, 1, 5'd10, 32'h0,         0, 4'h3, 32'h4000,   32'h0,        3,  1, 32'hFFFF_8001, 0);
    add(1, SW,       32'h6004,   32'h0BAD_F00D, 32'h0,       0, 0, 5'd0,  32'h0,         1, 4'h0, 32'h6004,   32'h0BAD_F00D, 1, 0, 32'h0,         0);
    add(1, SH,       32'h7002,   32'hFFFF_BEEF, 32'h0,       0, 0, 5'd0,  32'h0,         1, 4'h3, 32'h7000,   32'hBEEF_BEEF, 1, 0, 32'h0,         0);
    add(1, LBU,      32'h8001,   32'h0,        32'h0000_9C00, 0, 1, 5'd12, 32'h0,         0, 4'hD, 32'h8000,   32'h0,        1,  1, 32'h0000_009C, 0);
    add(1, LW,       32'h9000,   32'h0,        32'h0,        -1, 1, 5'd13, 32'h0,         0, 4'h0, 32'h9000,   32'h0,        16, 0, 32'h0,         1);
    add(1, LB,       32'hA000,   32'h0,        32'h0000_007F, 0, 1, 5'd14, 32'h0,         0, 4'hE, 32'hA000,   32'h0,        1,  1, 32'h0000_007F, 0);
    add(0, LW,       32'h1000,   32'h0,        32'h0,        0,  1, 5'd6,  32'h1234_5678, 0, 4'hF, 32'h0,      32'h0,        0,  0, 32'h0,         0);
    add(1, MEM_NONE, 32'h0,      32'h0,        32'h0,        0,  0, 5'd8,  32'h5555_AAAA, 0, 4'hF, 32'h0,      32'h0,        0,  0, 32'h0,         0);
`ifndef MEM_ALIGN_CHK_EN
    add(1, LH,       32'h4001,   32'h0,        32'h1234_F00D, 0, 1, 5'd15, 32'h0,         0, 4'hC, 32'h4000,   32'h0,        1,  1, 32'hFFFF_F00D, 0);
    add(1, LW,       32'h1002,   32'h0,        32'h1357_2468, 1, 1, 5'd16, 32'h0,         0, 4'h0, 32'h1000,   32'h0,        2,  1, 32'h1357_2468, 0);
    add(1, SH,       32'h2003,   32'h0000_ABCD, 32'h0,       0, 0, 5'd0,  32'h0,         1, 4'h3, 32'h2000,   32'hABCD_ABCD, 1, 0, 32'h0,         0);
`endif

    repeat (2) @(posedge CLK);
    #1;
    chk("reset.ce", sram_if.SRAM_CE, 1'b0);
    chk("reset.we", sram_if.SRAM_WE, 1'b0);
    chk("reset.addr", sram_if.SRAM_ADDR, 32'h0);
    chk("reset.be", sram_if.SRAM_BE, 4'hF);
    chk("reset.wdata", sram_if.SRAM_WDATA, 32'h0);
    chk("reset.gpr_we", GPR_WE_O, 1'b0);
    chk("reset.gpr_waddr", GPR_WADDR_O, 5'd0);
    chk("reset.gpr_wdata", GPR_WDATA_O, 32'h0);
    chk("reset.bus_err", BUS_ERR_O, 1'b0);
    chk("reset.stall", STALL_REQ, 1'b0);
    RST = 1'b0;

    foreach (vecs[k]) run_vec(k, vecs[k]);

`ifdef MEM_ALIGN_CHK_EN
    VALID_I = 1'b1; MEM_OP = LW; MEM_ADDR_I = 32'h1002; GPR_WE_I = 1'b1; GPR_WADDR_I = 5'd17;
    @(negedge CLK);
    chk("align.stall", STALL_REQ, 1'b0);
    @(posedge CLK); #1;
    VALID_I = 1'b0;
    chk("align.addr_err", ADDR_ERR_O, 1'b1);
    chk("align.gpr_we", GPR_WE_O, 1'b0);
    chk("align.ce", sram_if.SRAM_CE, 1'b0);
    @(posedge CLK); #1;
    chk("align.addr_err_pulse", ADDR_ERR_O, 1'b0);
    chk("align.ce_after", sram_if.SRAM_CE, 1'b0);
`endif

    VALID_I = 1'b1; MEM_OP = LW; MEM_ADDR_I = 32'hB000; GPR_WE_I = 1'b1; GPR_WADDR_I = 5'd20;
    sram_if.SRAM_READY = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    @(negedge CLK);
    chk("rst.pre_stall", STALL_REQ, 1'b1);
    RST = 1'b1; VALID_I = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("rst.ce", sram_if.SRAM_CE, 1'b0);
    chk("rst.be", sram_if.SRAM_BE, 4'hF);
    chk("rst.gpr_we", GPR_WE_O, 1'b0);
    chk("rst.bus_err", BUS_ERR_O, 1'b0);
    chk("rst.stall", STALL_REQ, 1'b0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      if (BUS_ERR_O || GPR_WE_O || sram_if.SRAM_CE) seen = 1'b1;
    end
    chk("rst.abandoned", seen, 1'b0);
    @(posedge CLK); #1;
    run_vec(99, vecs[8]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
